neuron_bus_arbiter: RTL and testbench
=====================================

// Module: neuron_bus_arbiter
// PURPOSE
//  N-master arbiter for the neuron memory port; successor to the 2-way ext/int mux.
//  Masters are the external loader, the layer sequencer and the debug port.
//  Masters request with req/grant; round-robin arbitration with a hold limit prevents starvation.
//  Bus outputs are registered: one clean, glitch-free driver into the neuron RAM.
// PARAMETERS
//  N_MASTERS   4    number of requesting masters (2..8)
//  ADDR_W      8    neuron read/write address width
//  DATA_W      8    neuron write data width
//  MAX_HOLD    16   max consecutive grant cycles while another master waits (>=1)
//  EXT_PRIO    1    1: master 0 (external) preempts at the next arbitration point; 0: pure round-robin
// PORTS
//  clk                    in   1               system clock, rising edge
//  reset_n                in   1               asynchronous active-low reset
//  req                    in   N_MASTERS       per-master bus request
//  rd_addr_in             in   N_MASTERS*ADDR_W packed; master i at [i*ADDR_W +: ADDR_W]
//  wr_addr_in             in   N_MASTERS*ADDR_W packed, same slicing
//  wr_data_in             in   N_MASTERS*DATA_W packed
//  wr_en_in               in   N_MASTERS       per-master write enable
//  grant                  out  N_MASTERS       one-hot or zero; registered
//  neuron_read_address    out  ADDR_W          registered bus read address
//  neuron_write_address   out  ADDR_W          registered bus write address
//  neuron_write_data      out  DATA_W          registered bus write data
//  neuron_write_enable    out  1               registered; asserted only for the granted master's wr_en
//  bus_busy               out  1               state==OWNED
// BEHAVIOUR
//  Reset (async assert, sync release): grant=0, all bus outputs=0, write_enable=0, state=IDLE,
//   rr_ptr=0, hold_cnt=0.
//  FSM IDLE: if |req, pick a winner; next cycle grant=onehot(winner), state=OWNED, hold_cnt=1.
//  FSM OWNED (owner o):
//   - req[o]==0 -> release: if other req pending, re-arbitrate same cycle (grant moves directly,
//     no idle bubble); else grant=0, state=IDLE.
//   - req[o]==1 and another req pending and hold_cnt==MAX_HOLD -> forced rotate to next winner.
//   - EXT_PRIO=1, o!=0, req[0]==1 -> preempt to master 0 next cycle regardless of hold_cnt.
//   - otherwise keep grant; hold_cnt saturates at MAX_HOLD; reset to 1 on every grant change.
//  Winner: EXT_PRIO && req[0] -> master 0; else first requester scanning from rr_ptr upward,
//   with wrap at N_MASTERS-1 -> 0. On each new grant to w, rr_ptr <= (w+1) mod N_MASTERS.
//  Datapath: each cycle the bus regs load the slice of the master granted for THAT cycle
//   (the grant register's next value). Bus reflects the new owner in the same cycle grant rises.
//   With no grant, write_enable=0; addresses and data hold their last value.
//  Latency: req rise -> grant 1 cycle (idle bus); master inputs -> bus outputs 1 cycle.
//  Handshake: a master drives its inputs only while grant[i]==1; inputs seen while ungranted are ignored.
//  Simultaneous release+new req by same master: treated as continue (req sampled level, not edge).
//  grant never has >1 bit set; invariant asserted in simulation.
//  Reset mid-transfer: bus drops immediately to zero and write_enable=0; no write completes.
// STRUCTURE
//  neuron_bus_pkg: NEURON_ADDR_W, NEURON_DATA_W defaults; function onehot_to_idx.
//  Sub-module rr_priority_picker (req, ptr, prio0_en -> winner idx, valid): combinational.
//  Top: FSM, hold counter ($clog2(MAX_HOLD+1) bits), rr_ptr, output regs, slice mux.
// TESTING
//  T1 reset: assert reset_n=0 mid-write -> all outputs 0 asynchronously, grant=0.
//  T2 single: req=4'b0010, m1 wr_addr=8'h3A, data=8'h5C, wr_en=1 -> next clk grant=0010;
//     bus addr=3A, data=5C, wren=1.
//  T3 round-robin (EXT_PRIO=0): req=4'b1111 held, MAX_HOLD=2 -> grant sequence 0,0,1,1,2,2,3,3,0 (2 cycles each).
//  T4 preempt: m2 owns, req[0] rises -> grant=0001 one cycle later, hold_cnt=1, wren follows m0.
//  T5 handover: m1 drops req while m3 requests -> grant 0010->1000 with no zero cycle.
//  T6 ignore: m2 ungranted drives wr_en=1, addr=FF -> neuron_write_enable stays 0, address unchanged.

Source files
------------

// File: rtl/neuron_bus_arbiter_pkg.sv
// Purpose: shared widths, FSM encodings and helpers for the neuron memory port arbiter.
// Contents: default address/data widths, FSM state constants, onehot_to_idx().
package neuron_bus_arbiter_pkg;

  localparam int unsigned NEURON_ADDR_W = 8;
  localparam int unsigned NEURON_DATA_W = 8;
  localparam int unsigned MAX_MASTERS   = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  // Index of the set bit of a one-hot (or zero) vector; zero input maps to 0.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/neuron_bus_arbiter_if.sv
// Purpose: request/grant and neuron RAM bus bundle between the masters and the arbiter.
// master modport: drives req and the packed per-master address/data/enable slices.
// slave modport : the arbiter; drives grant, the registered RAM bus and bus_busy.
interface neuron_bus_arbiter_if
  import neuron_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned ADDR_W    = NEURON_ADDR_W,
  parameter int unsigned DATA_W    = NEURON_DATA_W
);

  logic [N_MASTERS-1:0]        req;
  logic [N_MASTERS*ADDR_W-1:0] rd_addr_in;
  logic [N_MASTERS*ADDR_W-1:0] wr_addr_in;
  logic [N_MASTERS*DATA_W-1:0] wr_data_in;
  logic [N_MASTERS-1:0]        wr_en_in;

  logic [N_MASTERS-1:0]        grant;
  logic [ADDR_W-1:0]           neuron_read_address;
  logic [ADDR_W-1:0]           neuron_write_address;
  logic [DATA_W-1:0]           neuron_write_data;
  logic                        neuron_write_enable;
  logic                        bus_busy;

  modport master (
    output req, rd_addr_in, wr_addr_in, wr_data_in, wr_en_in,
    input  grant, neuron_read_address, neuron_write_address, neuron_write_data,
           neuron_write_enable, bus_busy
  );

  modport slave (
    input  req, rd_addr_in, wr_addr_in, wr_data_in, wr_en_in,
    output grant, neuron_read_address, neuron_write_address, neuron_write_data,
           neuron_write_enable, bus_busy
  );

endinterface

// File: rtl/neuron_bus_arbiter_rr_priority_picker.sv
// Purpose: combinational round-robin winner select with optional master-0 priority.
// req_i      : candidate requests
// ptr_i      : first index to scan (round-robin pointer)
// prio0_en_i : master 0 wins outright when it requests
// winner_c   : selected master index, valid_c : some request was present
module rr_priority_picker #(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned IDX_W     = 2
) (
  input  logic [N_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  input  logic                 prio0_en_i,
  output logic [IDX_W-1:0]     winner_c,
  output logic                 valid_c
);

  localparam int unsigned SW = IDX_W + 1;

  logic [SW-1:0]    sum;
  logic [IDX_W-1:0] idx;

  // Scan ptr, ptr+1, ... with wrap; first requester wins.
  always_comb begin
    winner_c = '0;
    valid_c  = 1'b0;
    sum      = '0;
    idx      = '0;
    if (prio0_en_i && req_i[0]) begin
      valid_c = 1'b1;
    end else begin
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
        sum = {1'b0, ptr_i} + SW'(i);
        if (sum >= SW'(N_MASTERS)) sum = sum - SW'(N_MASTERS);
        idx = sum[IDX_W-1:0];
        if (!valid_c && req_i[idx]) begin
          winner_c = idx;
          valid_c  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/neuron_bus_arbiter.sv
// Purpose: N-master round-robin arbiter with hold limit and optional external-master
//          preemption, driving a registered, glitch-free neuron RAM port.
// clk     : system clock, rising edge
// reset_n : asynchronous active-low reset
// bus     : slave side of neuron_bus_arbiter_if (requests/slices in, grant/RAM bus out)
module neuron_bus_arbiter
  import neuron_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned ADDR_W    = NEURON_ADDR_W,
  parameter int unsigned DATA_W    = NEURON_DATA_W,
  parameter int unsigned MAX_HOLD  = 16,
  parameter int unsigned EXT_PRIO  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  neuron_bus_arbiter_if.slave   bus
);

  localparam int unsigned IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  logic [0:0]           state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]    wr_data_q, wr_data_d;
  logic                 wr_en_q, wr_en_d;

  logic [IDX_W-1:0]     owner_c;
  logic [N_MASTERS-1:0] cand_req_c;
  logic [IDX_W-1:0]     winner_c;
  logic                 valid_c;
  logic                 owner_req_c;
  logic                 preempt_c;
  logic                 take_new_c;

  assign owner_c     = IDX_W'(onehot_to_idx(MAX_MASTERS'(grant_q)));
  assign owner_req_c = bus.req[owner_c];
  assign preempt_c   = (EXT_PRIO != 0) && (owner_c != '0) && bus.req[0];
  // While owned, the current owner is excluded so the picker finds the next candidate.
  assign cand_req_c  = (state_q == ST_OWNED) ? (bus.req & ~grant_q) : bus.req;

  rr_priority_picker #(
    .N_MASTERS (N_MASTERS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req_i      (cand_req_c),
    .ptr_i      (rr_ptr_q),
    .prio0_en_i (EXT_PRIO != 0),
    .winner_c   (winner_c),
    .valid_c    (valid_c)
  );

  // Next-state: grant ownership, hold counter, round-robin pointer.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    hold_d     = hold_q;
    take_new_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_c) take_new_c = 1'b1;
      end
      ST_OWNED: begin
        if (!owner_req_c) begin
          if (valid_c) begin
            take_new_c = 1'b1;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            hold_d  = '0;
          end
        end else if (preempt_c) begin
          take_new_c = 1'b1;
        end else if (valid_c && (hold_q == HOLD_W'(MAX_HOLD))) begin
          take_new_c = 1'b1;
        end else if (hold_q != HOLD_W'(MAX_HOLD)) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        hold_d  = '0;
      end
    endcase
    if (take_new_c) begin
      state_d  = ST_OWNED;
      grant_d  = N_MASTERS'(1) << winner_c;
      hold_d   = HOLD_W'(1);
      rr_ptr_d = (winner_c == IDX_W'(N_MASTERS - 1)) ? '0 : winner_c + IDX_W'(1);
    end
  end

  // Bus mux follows next-cycle grant so the bus changes together with grant.
  always_comb begin
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (grant_d[i]) begin
        rd_addr_d = bus.rd_addr_in[i*ADDR_W +: ADDR_W];
        wr_addr_d = bus.wr_addr_in[i*ADDR_W +: ADDR_W];
        wr_data_d = bus.wr_data_in[i*DATA_W +: DATA_W];
        wr_en_d   = bus.wr_en_in[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      hold_q    <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      hold_q    <= hold_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
    end
  end

  assign bus.grant                = grant_q;
  assign bus.neuron_read_address  = rd_addr_q;
  assign bus.neuron_write_address = wr_addr_q;
  assign bus.neuron_write_data    = wr_data_q;
  assign bus.neuron_write_enable  = wr_en_q;
  assign bus.bus_busy             = (state_q == ST_OWNED);

  grant_onehot0_a: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(grant_q));

endmodule

// File: tb/tb_neuron_bus_arbiter.sv
// Purpose: directed self-checking bench for neuron_bus_arbiter.
// dut_a: EXT_PRIO=1, MAX_HOLD=16 (reset, single grant, ignore, handover, preempt).
// dut_b: EXT_PRIO=0, MAX_HOLD=2 (round-robin rotation).
module tb_neuron_bus_arbiter;

  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  neuron_bus_arbiter_if #(.N_MASTERS(4), .ADDR_W(8), .DATA_W(8)) ifa ();
  neuron_bus_arbiter_if #(.N_MASTERS(4), .ADDR_W(8), .DATA_W(8)) ifb ();

  neuron_bus_arbiter #(
    .N_MASTERS(4), .ADDR_W(8), .DATA_W(8), .MAX_HOLD(16), .EXT_PRIO(1)
  ) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifa)
  );

  neuron_bus_arbiter #(
    .N_MASTERS(4), .ADDR_W(8), .DATA_W(8), .MAX_HOLD(2), .EXT_PRIO(0)
  ) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input int i, input logic r, input logic [7:0] ra,
                       input logic [7:0] wa, input logic [7:0] wd, input logic we);
    ifa.req[i]               = r;
    ifa.rd_addr_in[i*8 +: 8] = ra;
    ifa.wr_addr_in[i*8 +: 8] = wa;
    ifa.wr_data_in[i*8 +: 8] = wd;
    ifa.wr_en_in[i]          = we;
  endtask

  task automatic set_b(input int i, input logic r, input logic [7:0] wa, input logic we);
    ifb.req[i]               = r;
    ifb.rd_addr_in[i*8 +: 8] = wa ^ 8'hFF;
    ifb.wr_addr_in[i*8 +: 8] = wa;
    ifb.wr_data_in[i*8 +: 8] = wa + 8'h01;
    ifb.wr_en_in[i]          = we;
  endtask

  initial begin
    int         seq [9];
    logic [3:0] g;
    logic [7:0] a;
    seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

    reset_n = 1'b0;
    ifa.req = '0; ifa.rd_addr_in = '0; ifa.wr_addr_in = '0; ifa.wr_data_in = '0; ifa.wr_en_in = '0;
    ifb.req = '0; ifb.rd_addr_in = '0; ifb.wr_addr_in = '0; ifb.wr_data_in = '0; ifb.wr_en_in = '0;
    tick(); tick();

    // Reset state
    chk("rst_grant", 32'(ifa.grant), 32'h0);
    chk("rst_busy",  32'(ifa.bus_busy), 32'h0);
    chk("rst_wren",  32'(ifa.neuron_write_enable), 32'h0);
    chk("rst_waddr", 32'(ifa.neuron_write_address), 32'h0);
    chk("rst_b_grant", 32'(ifb.grant), 32'h0);
    reset_n = 1'b1;
    tick();

    // T3 round-robin on dut_b, all four requesting, hold limit 2
    for (int i = 0; i < 4; i++) set_b(i, 1'b1, 8'hB0 + 8'(i), 1'b1);
    for (int k = 0; k < 9; k++) begin
      tick();
      g = 4'b0001 << seq[k];
      a = 8'hB0 + 8'(seq[k]);
      chk($sformatf("rr_grant_%0d", k), 32'(ifb.grant), 32'(g));
      chk($sformatf("rr_waddr_%0d", k), 32'(ifb.neuron_write_address), 32'(a));
    end
    for (int i = 0; i < 4; i++) set_b(i, 1'b0, 8'h00, 1'b0);
    tick();
    chk("rr_release", 32'(ifb.grant), 32'h0);

    // T2 single request from m1
    set_a(1, 1'b1, 8'h11, 8'h3A, 8'h5C, 1'b1);
    chk("t2_pre_grant", 32'(ifa.grant), 32'h0);
    tick();
    chk("t2_grant", 32'(ifa.grant), 32'h2);
    chk("t2_waddr", 32'(ifa.neuron_write_address), 32'h3A);
    chk("t2_wdata", 32'(ifa.neuron_write_data), 32'h5C);
    chk("t2_raddr", 32'(ifa.neuron_read_address), 32'h11);
    chk("t2_wren",  32'(ifa.neuron_write_enable), 32'h1);
    chk("t2_busy",  32'(ifa.bus_busy), 32'h1);

    // T6 ungranted m2 drives a write; bus must keep following m1 only
    set_a(2, 1'b0, 8'hEE, 8'hFF, 8'hDD, 1'b1);
    tick();
    chk("t6_waddr_m1", 32'(ifa.neuron_write_address), 32'h3A);
    chk("t6_wren_m1",  32'(ifa.neuron_write_enable), 32'h1);
    set_a(1, 1'b1, 8'h11, 8'h3A, 8'h5C, 1'b0);
    tick();
    chk("t6_wren_off", 32'(ifa.neuron_write_enable), 32'h0);
    chk("t6_waddr",    32'(ifa.neuron_write_address), 32'h3A);
    set_a(1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    chk("t6_idle_grant", 32'(ifa.grant), 32'h0);
    chk("t6_idle_wren",  32'(ifa.neuron_write_enable), 32'h0);
    chk("t6_idle_waddr", 32'(ifa.neuron_write_address), 32'h3A);
    chk("t6_idle_busy",  32'(ifa.bus_busy), 32'h0);
    set_a(2, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

    // T5 handover m1 -> m3 with no idle cycle
    set_a(1, 1'b1, 8'h12, 8'h21, 8'h22, 1'b1);
    tick();
    chk("t5_grant_m1", 32'(ifa.grant), 32'h2);
    set_a(1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    set_a(3, 1'b1, 8'h34, 8'h33, 8'h35, 1'b1);
    tick();
    chk("t5_grant_m3", 32'(ifa.grant), 32'h8);
    chk("t5_waddr",    32'(ifa.neuron_write_address), 32'h33);
    chk("t5_wdata",    32'(ifa.neuron_write_data), 32'h35);

    // T4 m2 takes over from m3, then m0 preempts
    set_a(3, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    set_a(2, 1'b1, 8'h43, 8'h42, 8'h44, 1'b1);
    tick();
    chk("t4_grant_m2", 32'(ifa.grant), 32'h4);
    chk("t4_waddr_m2", 32'(ifa.neuron_write_address), 32'h42);
    tick();
    chk("t4_hold_m2",  32'(ifa.grant), 32'h4);
    set_a(0, 1'b1, 8'h0B, 8'h0A, 8'hB0, 1'b1);
    tick();
    chk("t4_grant_m0", 32'(ifa.grant), 32'h1);
    chk("t4_hold_cnt", 32'(dut_a.hold_q), 32'h1);
    chk("t4_waddr_m0", 32'(ifa.neuron_write_address), 32'h0A);
    chk("t4_wdata_m0", 32'(ifa.neuron_write_data), 32'hB0);
    chk("t4_wren_m0",  32'(ifa.neuron_write_enable), 32'h1);
    tick();
    chk("t4_keep_m0",  32'(ifa.grant), 32'h1);
    chk("t4_hold_cnt2", 32'(dut_a.hold_q), 32'h2);
    set_a(0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    set_a(2, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    chk("t4_release", 32'(ifa.grant), 32'h0);

    // T1 asynchronous reset in the middle of a write
    set_a(1, 1'b1, 8'h78, 8'h77, 8'h79, 1'b1);
    tick();
    chk("t1_pre_wren", 32'(ifa.neuron_write_enable), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t1_grant", 32'(ifa.grant), 32'h0);
    chk("t1_wren",  32'(ifa.neuron_write_enable), 32'h0);
    chk("t1_waddr", 32'(ifa.neuron_write_address), 32'h0);
    chk("t1_raddr", 32'(ifa.neuron_read_address), 32'h0);
    chk("t1_wdata", 32'(ifa.neuron_write_data), 32'h0);
    chk("t1_busy",  32'(ifa.bus_busy), 32'h0);
    tick();
    chk("t1_held_grant", 32'(ifa.grant), 32'h0);
    reset_n = 1'b1;
    set_a(1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    chk("t1_after_grant", 32'(ifa.grant), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
